display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clocks per digit slot, legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_valid, input, 1 bit: a new display word is offered.
REQ-005 SHALL have port wr_ready, output, 1 bit: the block can accept a new word.
REQ-006 SHALL have port wr_data, input, 32 bits: eight hex nibbles; nibble k = wr_data[4k+3:4k] for digit k.
REQ-007 SHALL have port dp_in, input, 8 bits: decimal-point enables, bit k for digit k, captured together with wr_data.
REQ-008 SHALL have port digit, output, 4 bits: the active hex nibble, driven to the 7-segment decoder W,X,Y,Z inputs (bit3 = W).
REQ-009 SHALL have port sel, output, 3 bits: the active digit index, driven to the 3-to-8 anode decoder I,J,K inputs (bit2 = I).
REQ-010 SHALL have port dp, output, 1 bit: the decimal point for the active digit.
REQ-011 SHALL have port blank, output, 1 bit: when 1, the active digit is to be blanked.
REQ-012 SHALL have port frame_start, output, 1 bit: a one-cycle pulse when the scan wraps to digit 0.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick is asserted in the cycle where the count equals PRESCALE-1.
- With PRESCALE=1, tick SHALL assert every cycle.
REQ-014 On each tick, idx SHALL advance by one modulo 8 (7 wraps to 0); between ticks idx SHALL hold.
REQ-015 The outputs sel, digit and dp SHALL equal idx, disp_reg nibble[idx] and disp_dp[idx] respectively.
- All three SHALL be driven from registers only.
- No combinational path SHALL exist from wr_data or dp_in to any output.
REQ-016 The write FSM SHALL have two states: EMPTY and PENDING.
- wr_ready SHALL equal 1 only in EMPTY.
REQ-017 In EMPTY, wr_valid=1 SHALL capture wr_data and dp_in into a shadow register and move the FSM to PENDING; wr_ready SHALL be 0 from the next cycle.
REQ-018 In PENDING, on the tick that wraps idx from 7 to 0, the shadow register SHALL be copied into disp_reg/disp_dp and the FSM SHALL return to EMPTY.
- This makes the displayed value change only at a frame boundary (no tearing).
REQ-019 A write accepted in the same cycle as a 7->0 wrap tick SHALL be displayed at the following frame boundary, not the current one.
REQ-020 wr_valid while in PENDING SHALL be ignored.
- Shadow register and disp_reg SHALL be unchanged by it.
REQ-021 frame_start SHALL be 1 for exactly the one cycle after the 7->0 wrap tick, i.e. the first cycle with sel=0 of each frame.
- The new disp_reg value SHALL be visible in that same cycle.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL clear:
- prescaler = 0, idx = 0, disp_reg = 0, disp_dp = 0, shadow register = 0;
- FSM = EMPTY.
REQ-023 The cycle after reset, outputs SHALL be: digit=0, sel=0, dp=0, blank=0, frame_start=0, wr_ready=1.
REQ-024 Reset asserted mid-frame or while in PENDING SHALL discard the pending word; no partial update SHALL occur.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined, blank SHALL be 1 when idx is greater than the index of the most significant nonzero nibble of disp_reg.
- Digit 0 SHALL never be blanked, so disp_reg=0 shows a single "0".
- blank SHALL be registered and aligned with digit/sel.
REQ-026 Without LEADING_ZERO_BLANK_EN, blank SHALL be tied to 0.

Verification (PRESCALE=4)
REQ-027 Reset, then idle 40 cycles -> sel steps 0..7 every 4 cycles and wraps to 0; frame_start pulses every 32 cycles; digit=0 throughout.
REQ-028 Write 0x89ABCDEF with dp_in=0x01 mid-frame -> wr_ready=0 until the next wrap; from frame_start onward, sel=0 shows digit=F with dp=1 and sel=7 shows digit=8; wr_ready=1 the cycle after the wrap.
REQ-029 Write 0x11111111 while PENDING with 0x22222222 -> the second write is ignored; the next frame shows all digits = 2.
REQ-030 Assert wr_valid on the 7->0 wrap tick with 0x00000005 -> value appears one frame later, not the current one.
REQ-031 With LEADING_ZERO_BLANK_EN, disp_reg=0x00000305 -> blank=1 for sel 3..7, blank=0 for sel 0..2; with disp_reg=0, only sel=0 is unblanked.
REQ-032 Assert reset while PENDING at sel=5 -> the next cycle shows sel=0, digit=0, wr_ready=1; the old word is never displayed.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed hex display scanner with a tear-free, frame-aligned write port.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  dp_in,
    output logic [3:0]  digit,
    output logic [2:0]  sel,
    output logic        dp,
    output logic        blank,
    output logic        frame_start
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    typedef enum logic {
        EMPTY,
        PENDING
    } wr_state_t;

    wr_state_t   state, state_nxt;
    logic [15:0] pre_cnt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic        tick;
    logic        wrap;
    logic        capture;
    logic        load;

    logic [31:0] shadow_data;
    logic [7:0]  shadow_dp;
    logic [31:0] disp_reg;
    logic [7:0]  disp_dp;
    logic [31:0] disp_nxt;
    logic [7:0]  disp_dp_nxt;

    function automatic logic [3:0] nibble_at(input logic [31:0] w, input logic [2:0] k);
        nibble_at = w[{k, 2'b00} +: 4];
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the word is all zero.
    function automatic logic [2:0] msb_nibble(input logic [31:0] w);
        msb_nibble = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w[4*k +: 4] != 4'd0) begin
                msb_nibble = 3'(k);
            end
        end
    endfunction

    function automatic logic blank_for(input logic [31:0] w, input logic [2:0] k);
        blank_for = (k > msb_nibble(w));
    endfunction
`endif

    assign tick     = (pre_cnt == PS_LAST);
    assign wrap     = tick && (idx == 3'd7);
    assign capture  = (state == EMPTY) && wr_valid;
    assign load     = (state == PENDING) && wrap;
    assign wr_ready = (state == EMPTY);
    assign sel      = idx;

    always_comb begin
        idx_nxt     = tick ? idx + 3'd1 : idx;
        disp_nxt    = load ? shadow_data : disp_reg;
        disp_dp_nxt = load ? shadow_dp : disp_dp;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (wr_valid) state_nxt = PENDING;
            PENDING: if (wrap)     state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Prescaler and scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= 16'd0;
            idx     <= 3'd0;
            state   <= EMPTY;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            idx     <= idx_nxt;
            state   <= state_nxt;
        end
    end

    // Shadow capture and frame-boundary display update
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data <= 32'd0;
            shadow_dp   <= 8'd0;
            disp_reg    <= 32'd0;
            disp_dp     <= 8'd0;
        end else begin
            if (capture) begin
                shadow_data <= wr_data;
                shadow_dp   <= dp_in;
            end
            disp_reg <= disp_nxt;
            disp_dp  <= disp_dp_nxt;
        end
    end

    // Output registers are loaded from next-state values so they line up with sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit       <= 4'd0;
            dp          <= 1'b0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            digit       <= nibble_at(disp_nxt, idx_nxt);
            dp          <= disp_dp_nxt[idx_nxt];
`ifdef LEADING_ZERO_BLANK_EN
            blank       <= blank_for(disp_nxt, idx_nxt);
`else
            blank       <= 1'b0;
`endif
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl at PRESCALE=4: frame-arithmetic reference model,
// a table of directed writes, hand-written corner sequences and random traffic.
module tb_display_scan_ctrl;

    localparam int PS    = 4;
    localparam int FRAME = 8 * PS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  dp_in = 8'd0;
    logic [3:0]  digit;
    logic [2:0]  sel;
    logic        dp;
    logic        blank;
    logic        frame_start;

    always #5 clk = ~clk;

    display_scan_ctrl #(.PRESCALE(PS)) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .dp_in(dp_in),
        .digit(digit),
        .sel(sel),
        .dp(dp),
        .blank(blank),
        .frame_start(frame_start)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: n = cycles since reset, displayed word, one-deep pending word.
    int          n;
    logic [31:0] m_disp, m_shadow;
    logic [7:0]  m_dpd, m_sdp;
    bit          m_pend;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dpv;
        int          off;
        bit          second;
        logic [31:0] data2;
        logic [3:0]  d0;
        logic [3:0]  d7;
        logic        dp0;
        logic [7:0]  bmask;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic int msb_idx(input logic [31:0] w);
        int m;
        m = 0;
        for (int k = 0; k < 8; k++) begin
            if (w[4*k +: 4] != 4'd0) m = k;
        end
        return m;
    endfunction

    task automatic model_reset();
        n        = 0;
        m_disp   = 32'd0;
        m_shadow = 32'd0;
        m_dpd    = 8'd0;
        m_sdp    = 8'd0;
        m_pend   = 1'b0;
    endtask

    task automatic check_model();
        int   s;
        logic eb;
        s = (n / PS) % 8;
`ifdef LEADING_ZERO_BLANK_EN
        eb = (s > msb_idx(m_disp));
`else
        eb = 1'b0;
`endif
        chk("sel", 32'(sel), s);
        chk("digit", 32'(digit), 32'(m_disp[4*s +: 4]));
        chk("dp", 32'(dp), 32'(m_dpd[s]));
        chk("blank", 32'(blank), 32'(eb));
        chk("frame_start", 32'(frame_start), 32'((n > 0) && (n % FRAME == 0)));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    endtask

    // Compare the current cycle, drive inputs for it, advance one clock.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic [7:0] p);
        check_model();
        reset    = r;
        wr_valid = v;
        wr_data  = d;
        dp_in    = p;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if ((n % FRAME == FRAME - 1) && m_pend) begin
                m_disp = m_shadow;
                m_dpd  = m_sdp;
                m_pend = 1'b0;
            end else if (!m_pend && v) begin
                m_shadow = d;
                m_sdp    = p;
                m_pend   = 1'b1;
            end
            n++;
        end
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    task automatic wait_offset(input int off);
        int guard;
        guard = 0;
        while ((n % FRAME != off) && (guard < 2 * FRAME)) begin
            idle(1);
            guard++;
        end
        chk("wait_offset_bound", 32'(n % FRAME), 32'(off));
    endtask

    initial begin
        int fs_count;
        logic        r, v;
        logic [31:0] d;

        tbl[0] = '{data: 32'h89ABCDEF, dpv: 8'h01, off: 10, second: 1'b0, data2: 32'h0,
                   d0: 4'hF, d7: 4'h8, dp0: 1'b1, bmask: 8'h00};
        tbl[1] = '{data: 32'h22222222, dpv: 8'h80, off: 5, second: 1'b1, data2: 32'h11111111,
                   d0: 4'h2, d7: 4'h2, dp0: 1'b0, bmask: 8'h00};
        tbl[2] = '{data: 32'h00000305, dpv: 8'h04, off: 17, second: 1'b0, data2: 32'h0,
                   d0: 4'h5, d7: 4'h0, dp0: 1'b0, bmask: 8'hF8};
        tbl[3] = '{data: 32'h00000000, dpv: 8'h00, off: 28, second: 1'b1, data2: 32'hFFFFFFFF,
                   d0: 4'h0, d7: 4'h0, dp0: 1'b0, bmask: 8'hFE};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_sel", 32'(sel), 0);
        chk("reset_digit", 32'(digit), 0);
        chk("reset_dp", 32'(dp), 0);
        chk("reset_blank", 32'(blank), 0);
        chk("reset_frame_start", 32'(frame_start), 0);
        chk("reset_wr_ready", 32'(wr_ready), 1);

        // Idle scan: one frame_start in 40 cycles (at cycle 32)
        fs_count = 0;
        for (int i = 0; i < 40; i++) begin
            if (frame_start === 1'b1) fs_count++;
            idle(1);
        end
        chk("idle_frame_start_count", fs_count, 1);

        for (int i = 0; i < 4; i++) begin
            wait_offset(tbl[i].off);
            chk("tbl_ready_before", 32'(wr_ready), 1);
            cycle(1'b0, 1'b1, tbl[i].data, tbl[i].dpv);
            chk("tbl_ready_after_accept", 32'(wr_ready), 0);
            if (tbl[i].second) begin
                idle(1);
                cycle(1'b0, 1'b1, tbl[i].data2, 8'hFF);
            end
            wait_offset(0);
            chk("tbl_frame_start", 32'(frame_start), 1);
            chk("tbl_sel0", 32'(sel), 0);
            chk("tbl_digit0", 32'(digit), 32'(tbl[i].d0));
            chk("tbl_dp0", 32'(dp), 32'(tbl[i].dp0));
            chk("tbl_ready_after_wrap", 32'(wr_ready), 1);
            for (int s = 0; s < 8; s++) begin
`ifdef LEADING_ZERO_BLANK_EN
                chk("tbl_blank", 32'(blank), 32'(tbl[i].bmask[s]));
`else
                chk("tbl_blank", 32'(blank), 0);
`endif
                if (s == 7) chk("tbl_digit7", 32'(digit), 32'(tbl[i].d7));
                idle(PS);
            end
        end

        // Write offered on the wrap tick lands one frame later
        wait_offset(FRAME - 1);
        cycle(1'b0, 1'b1, 32'h00000005, 8'h00);
        chk("wrapwr_frame_start", 32'(frame_start), 1);
        chk("wrapwr_old_digit", 32'(digit), 0);
        chk("wrapwr_pending", 32'(wr_ready), 0);
        idle(1);
        wait_offset(0);
        chk("wrapwr_new_digit", 32'(digit), 5);
        chk("wrapwr_ready", 32'(wr_ready), 1);

        // Reset while pending at sel=5 discards the word
        wait_offset(2);
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 8'hFF);
        wait_offset(20);
        chk("rstpend_sel5", 32'(sel), 5);
        chk("rstpend_pending", 32'(wr_ready), 0);
        cycle(1'b1, 1'b0, 32'd0, 8'd0);
        chk("rstpend_sel", 32'(sel), 0);
        chk("rstpend_digit", 32'(digit), 0);
        chk("rstpend_ready", 32'(wr_ready), 1);
        chk("rstpend_dp", 32'(dp), 0);
        idle(3 * FRAME);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 7) == 0);
            d = $urandom >> $urandom_range(0, 31);
            cycle(r, v, d, 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
